// File: rtl/boron_dec_sequencer.sv
// Control sequencer for the Boron decryption datapath: accepts one block via valid/ready, runs the
// forward key schedule, then ROUNDS inverse rounds, then final whitening, and holds the result until it is popped.
module boron_dec_sequencer #(
  parameter int ROUNDS = 25,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             abort,
  output logic             busy,
  output logic             load_s,
  output logic             key_gen_s,
  output logic             round_one_s,
  output logic             final_s,
  output logic             text_we,
  output logic             key_we,
  output logic [CNT_W-1:0] round_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_KEYGEN = 3'd2,
    S_FIRST  = 3'd3,
    S_ROUND  = 3'd4,
    S_FINAL  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ROUNDS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Counter is primed on accept so LOAD already presents round constant 1.
          if (in_valid) begin
            state_d = S_LOAD;
            cnt_d   = CNT_ONE;
          end
        end
        S_LOAD: begin
          state_d = S_KEYGEN;
          cnt_d   = CNT_ONE;
        end
        S_KEYGEN: begin
          if (cnt_q >= CNT_MAX) begin
            state_d = S_FIRST;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_FIRST: begin
          if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
          state_d = (cnt_q <= CNT_ONE) ? S_FINAL : S_ROUND;
        end
        S_ROUND: begin
          if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
          if (cnt_q <= CNT_ONE) state_d = S_FINAL;
        end
        S_FINAL: begin
          state_d = S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    load_s      = 1'b0;
    key_gen_s   = 1'b0;
    round_one_s = 1'b0;
    final_s     = 1'b0;
    text_we     = 1'b0;
    key_we      = 1'b0;
    out_valid   = 1'b0;
    case (state_q)
      S_LOAD: begin
        load_s  = 1'b1;
        text_we = 1'b1;
        key_we  = 1'b1;
      end
      S_KEYGEN: begin
        key_gen_s = 1'b1;
        key_we    = 1'b1;
      end
      S_FIRST: begin
        round_one_s = 1'b1;
        text_we     = 1'b1;
        key_we      = 1'b1;
      end
      S_ROUND: begin
        text_we = 1'b1;
        key_we  = 1'b1;
      end
      S_FINAL: begin
        final_s = 1'b1;
        text_we = 1'b1;
      end
      S_DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign round_cnt = cnt_q;

endmodule

// File: tb/tb_boron_dec_sequencer.sv
// Randomized and directed bench for boron_dec_sequencer against a timeline model of one block.
module tb_boron_dec_sequencer;

  localparam int R        = 25;
  localparam int DONE_POS = 2 * R + 3;

  logic       clk = 1'b0;
  logic       reset, in_valid, out_ready, abort;
  logic       in_ready, out_valid, busy;
  logic       load_s, key_gen_s, round_one_s, final_s, text_we, key_we;
  logic [4:0] round_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  // Model position: 0 idle, 1..2R+2 the active cycles of a block, DONE_POS waiting for pop.
  int pos   = 0;

  int tr_load, tr_kg_first, tr_kg_last, tr_kg_n, tr_first, tr_rd_first, tr_rd_last, tr_rd_n, tr_final;

  boron_dec_sequencer #(.ROUNDS(R), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .abort(abort), .busy(busy),
    .load_s(load_s), .key_gen_s(key_gen_s), .round_one_s(round_one_s), .final_s(final_s),
    .text_we(text_we), .key_we(key_we), .round_cnt(round_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] exp_vec(int p);
    logic ld, kg, fi, rd, fn;
    logic [4:0] c;
    ld = (p == 1);
    kg = (p >= 2) && (p <= R + 1);
    fi = (p == R + 2);
    rd = (p >= R + 3) && (p <= 2 * R + 1);
    fn = (p == 2 * R + 2);
    if (ld)      c = 5'd1;
    else if (kg) c = 5'(p - 1);
    else if (fi) c = 5'(R);
    else if (rd) c = 5'(2 * R + 2 - p);
    else         c = 5'd0;
    return {p == 0, p == DONE_POS, p != 0, ld, kg, fi, fn, ld | fi | rd | fn, ld | kg | fi | rd, c};
  endfunction

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic compare_outputs();
    logic [13:0] got, want;
    got  = {in_ready, out_valid, busy, load_s, key_gen_s, round_one_s, final_s, text_we, key_we, round_cnt};
    want = exp_vec(pos);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL outputs: got %b expected %b (cycle %0d, model pos %0d)", got, want, cyc, pos);
    end
    chk("select_onehot", int'($countones({load_s, key_gen_s, round_one_s, final_s}) <= 1), 1);
  endtask

  task automatic step();
    @(posedge clk);
    if (reset || abort)                 pos = 0;
    else if (pos == 0) begin if (in_valid) pos = 1; end
    else if (pos < DONE_POS)            pos = pos + 1;
    else if (out_ready)                 pos = 0;
    cyc++;
    #1;
    compare_outputs();
  endtask

  task automatic run_block(output int lat);
    int acc;
    acc = -1; lat = -1;
    tr_load = -1; tr_kg_first = -1; tr_kg_last = -1; tr_kg_n = 0;
    tr_first = -1; tr_rd_first = -1; tr_rd_last = -1; tr_rd_n = 0; tr_final = -1;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (acc < 0 && in_ready) acc = cyc;
      step();
      if (acc >= 0) in_valid = 1'b0;
      if (load_s) tr_load = int'(round_cnt);
      if (key_gen_s) begin
        if (tr_kg_first < 0) tr_kg_first = int'(round_cnt);
        tr_kg_last = int'(round_cnt);
        tr_kg_n++;
      end
      if (round_one_s) tr_first = int'(round_cnt);
      if (text_we && key_we && !load_s && !round_one_s) begin
        if (tr_rd_first < 0) tr_rd_first = int'(round_cnt);
        tr_rd_last = int'(round_cnt);
        tr_rd_n++;
      end
      if (final_s) tr_final = int'(round_cnt);
      if (out_valid) begin
        lat = cyc - acc;
        break;
      end
    end
  endtask

  initial begin
    int lat, ov_n, n_acc;
    int acc_c[3];
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    step();

    // Latency and round counter trace over one block.
    run_block(lat);
    chk("latency", lat, 53);
    chk("trace_load", tr_load, 1);
    chk("trace_keygen_first", tr_kg_first, 1);
    chk("trace_keygen_last", tr_kg_last, 25);
    chk("trace_keygen_cycles", tr_kg_n, 25);
    chk("trace_first", tr_first, 25);
    chk("trace_round_first", tr_rd_first, 24);
    chk("trace_round_last", tr_rd_last, 1);
    chk("trace_round_cycles", tr_rd_n, 24);
    chk("trace_final", tr_final, 0);
    step();
    chk("pop_to_idle", int'(in_ready), 1);

    // Reset held 3 cycles in the middle of the key schedule.
    in_valid = 1'b1;
    for (int i = 0; i < 40 && pos != 10; i++) begin
      step();
      if (pos != 0) in_valid = 1'b0;
    end
    chk("reached_keygen", int'(key_gen_s), 1);
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_round_cnt", int'(round_cnt), 0);
    chk("rst_selects", int'({load_s, key_gen_s, round_one_s, final_s}), 0);

    // Stall in DONE with stray requests.
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 100 && !out_valid; i++) step();
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      step();
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("stall_pop_idle", int'(in_ready), 1);

    // Abort in ROUND at round_cnt 12, then a clean block.
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (pos != 0) in_valid = 1'b0;
      if (pos == 2 * R + 2 - 12) break;
    end
    chk("abort_at_cnt12", int'(round_cnt), 12);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", int'(in_ready), 1);
    chk("abort_cnt", int'(round_cnt), 0);
    ov_n = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (out_valid) ov_n++;
    end
    chk("abort_no_out_valid", ov_n, 0);
    run_block(lat);
    chk("after_abort_latency", lat, 53);

    // Back-to-back requests with in_valid held high.
    step();
    in_valid = 1'b1; out_ready = 1'b1; n_acc = 0;
    for (int i = 0; i < 300 && n_acc < 3; i++) begin
      if (in_ready) begin
        acc_c[n_acc] = cyc;
        n_acc++;
      end
      step();
    end
    chk("b2b_accepts", n_acc, 3);
    if (n_acc == 3) begin
      chk("b2b_spacing_1", acc_c[1] - acc_c[0], 54);
      chk("b2b_spacing_2", acc_c[2] - acc_c[1], 54);
    end
    in_valid = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom % 3) == 0;
      out_ready = ($urandom % 2) == 0;
      abort     = ($urandom % 200) == 0;
      reset     = ($urandom % 500) == 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
